sshooter_ssg_hpf: RTL and testbench

SSHOOTER_SSG_HPF -- requirements
Module: sshooter_ssg_hpf

---
 rtl/sshooter_ssg_hpf.sv | 125 ++++++++++++
 tb/tb_sshooter_ssg_hpf.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sshooter_ssg_hpf.sv
// SSG output high-pass: a one-pole/one-zero IIR, evaluated once per DIV clocks
// with a single shared 18x18 multiplier. Register loads are sequenced by a small FSM.
module sshooter_ssg_hpf #(
  parameter int DIV = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         sel,
  input  logic signed [15:0] in,
  output logic signed [15:0] out,
  output logic               sample_stb
);

  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, DONE} state_t;

  state_t state, state_nx;

  logic [9:0]         cnt;
  logic               tick;
  logic [1:0]         sel_q;
  logic signed [15:0] x0, x1, y1;
  logic signed [39:0] acc;
  logic signed [17:0] b1, b2, a2;
  logic signed [17:0] mul_a, mul_b;
  logic signed [35:0] prod;
  logic signed [39:0] prod_ext;
  logic signed [39:0] r;
  logic signed [15:0] sat;

  assign tick = (cnt == 10'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else if (tick) cnt <= '0;
    else cnt <= cnt + 10'd1;
  end

  always_comb begin
    b1 = '0;
    b2 = '0;
    a2 = '0;
    case (sel_q)
      2'd1: begin b1 = 18'sd32748; b2 = -18'sd32748; a2 = -18'sd32728; end
      2'd2: begin b1 = 18'sd32632; b2 = -18'sd32632; a2 = -18'sd32497; end
      2'd3: begin b1 = 18'sd32180; b2 = -18'sd32180; a2 = -18'sd31592; end
      default: ;
    endcase
  end

  // One multiplier, operands chosen by the MAC step.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      MAC0: begin mul_a = b1; mul_b = {{2{x0[15]}}, x0}; end
      MAC1: begin mul_a = b2; mul_b = {{2{x1[15]}}, x1}; end
      MAC2: begin mul_a = a2; mul_b = {{2{y1[15]}}, y1}; end
      default: ;
    endcase
  end

  assign prod     = mul_a * mul_b;
  assign prod_ext = {{4{prod[35]}}, prod};
  assign r        = acc >>> 15;

  always_comb begin
    if (r > 40'sd32767) sat = 16'sh7fff;
    else if (r < -40'sd32768) sat = 16'sh8000;
    else sat = r[15:0];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (tick) state_nx = MAC0;
      MAC0:    state_nx = MAC1;
      MAC1:    state_nx = MAC2;
      MAC2:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0         <= '0;
      x1         <= '0;
      y1         <= '0;
      acc        <= '0;
      sel_q      <= '0;
      out        <= '0;
      sample_stb <= 1'b0;
    end else begin
      sample_stb <= 1'b0;
      case (state)
        IDLE: if (tick) begin
          x0    <= in;
          sel_q <= sel;
        end
        MAC0: acc <= prod_ext;
        MAC1: acc <= acc + prod_ext;
        MAC2: acc <= acc - prod_ext;
        DONE: begin
          // Bypass still walks the full MAC sequence so latency is select-independent.
          if (sel_q == 2'd0) begin
            out <= x0;
            y1  <= '0;
          end else begin
            out <= sat;
            y1  <= sat;
          end
          x1         <= x0;
          sample_stb <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sshooter_ssg_hpf.sv
// Directed bench for sshooter_ssg_hpf: table of hand-computed samples, corner
// sequences (select change, reset mid-sample, latency/period) and a reference model.
module tb_sshooter_ssg_hpf;

  localparam int DIVS = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic [1:0]         sel, sel256;
  logic signed [15:0] in, in256;
  logic signed [15:0] out, out256;
  logic               sample_stb, stb256;

  int checks = 0;
  int errors = 0;
  int mx1, my1;

  always #5 clk = ~clk;

  sshooter_ssg_hpf #(.DIV(DIVS)) dut (
    .clk(clk), .reset(reset), .sel(sel), .in(in), .out(out), .sample_stb(sample_stb)
  );

  sshooter_ssg_hpf #(.DIV(256)) dut256 (
    .clk(clk), .reset(reset), .sel(sel256), .in(in256), .out(out256), .sample_stb(stb256)
  );

  typedef struct {
    logic [1:0] s;
    int         x;
    int         y;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int hp(input int s, input int x0, input int x1, input int y1);
    longint acc;
    int b1, b2, a2;
    case (s)
      1: begin b1 = 32748; b2 = -32748; a2 = -32728; end
      2: begin b1 = 32632; b2 = -32632; a2 = -32497; end
      3: begin b1 = 32180; b2 = -32180; a2 = -31592; end
      default: return x0;
    endcase
    acc = longint'(b1) * x0 + longint'(b2) * x1 - longint'(a2) * y1;
    acc = acc >>> 15;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  function automatic int model_step(input int s, input int x0);
    int y;
    y   = hp(s, x0, mx1, my1);
    mx1 = x0;
    my1 = (s == 0) ? 0 : y;
    return y;
  endfunction

  // Called at a negedge; counts rising edges until the selected strobe is seen.
  task automatic wait_stb(input bit big, output int n, output bit ok);
    int lim;
    lim = big ? 3 * 256 : 3 * DIVS + 10;
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      n++;
      if ((big ? stb256 : sample_stb) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("stb_timeout", 0, 1);
  endtask

  task automatic step(input logic [1:0] s, input int x, output int got);
    int n;
    bit ok;
    sel = s;
    in  = 16'(x);
    wait_stb(1'b0, n, ok);
    got = int'(out);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mx1 = 0;
    my1 = 0;
  endtask

  initial begin
    vec_t tbl[10];
    int n, got, exp, prev, last;
    bit ok;

    tbl[0] = '{2'd0, -1234, -1234};
    tbl[1] = '{2'd0, 500, 500};
    tbl[2] = '{2'd1, 10000, 9494};
    tbl[3] = '{2'd1, 10000, 9482};
    tbl[4] = '{2'd2, 0, -555};
    tbl[5] = '{2'd3, 32767, 31643};
    tbl[6] = '{2'd3, -32768, -32768};
    tbl[7] = '{2'd3, 32767, 32767};
    tbl[8] = '{2'd3, -32768, -32768};
    tbl[9] = '{2'd3, 32767, 32767};

    reset  = 1'b1;
    sel    = 2'd0;
    in     = '0;
    sel256 = 2'd0;
    in256  = -16'sd1234;
    mx1 = 0;
    my1 = 0;
    repeat (3) @(negedge clk);
    chk("reset_out", int'(out), 0);
    chk("reset_stb", int'(sample_stb), 0);
    chk("reset_out256", int'(out256), 0);
    reset = 1'b0;

    // Bypass at DIV=256: strobe 256+4 edges after release, period 256, one clock wide.
    wait_stb(1'b1, n, ok);
    chk("bypass_latency", n, 260);
    chk("bypass_out", int'(out256), -1234);
    @(negedge clk);
    chk("bypass_stb_width", int'(stb256), 0);
    wait_stb(1'b1, n, ok);
    chk("bypass_period", n + 1, 256);
    chk("bypass_out2", int'(out256), -1234);

    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].s, tbl[i].x, got);
      chk($sformatf("table_%0d", i), got, tbl[i].y);
    end

    // Select changes while the sample is in MAC1: captured select must win.
    pulse_reset();
    step(2'd1, 3000, got);
    chk("selchg_sync", got, model_step(1, 3000));
    sel = 2'd1;
    in  = 16'sd5000;
    repeat (5) @(posedge clk);
    @(negedge clk);
    sel = 2'd3;
    in  = -16'sd7000;
    wait_stb(1'b0, n, ok);
    chk("selchg_cur", int'(out), model_step(1, 5000));
    wait_stb(1'b0, n, ok);
    chk("selchg_next", int'(out), model_step(3, -7000));

    // Reset during MAC2 drops that sample; next tick comes DIV edges after release.
    sel = 2'd2;
    in  = 16'sd12345;
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstmid_out", int'(out), 0);
    chk("rstmid_stb", int'(sample_stb), 0);
    @(negedge clk);
    reset = 1'b0;
    mx1 = 0;
    my1 = 0;
    wait_stb(1'b0, n, ok);
    chk("rstmid_latency", n, DIVS + 4);
    chk("rstmid_out_after", int'(out), 12293);

    // DC step with sel 1: floor of 32748*10000/32768 is 9993, then monotone decay.
    pulse_reset();
    step(2'd1, 10000, got);
    chk("dc_first", got, 9993);
    exp = model_step(1, 10000);
    prev = got;
    last = got;
    for (int i = 1; i < 4000; i++) begin
      step(2'd1, 10000, got);
      exp = model_step(1, 10000);
      if (got !== exp || got > prev) chk($sformatf("dc_%0d", i), got, exp);
      prev = got;
      last = got;
    end
    chk("dc_monotone_end", int'(last <= prev), 1);
    chk("dc_small", int'(last < 16 && last > -16), 1);

    // Random select and input against the reference model.
    pulse_reset();
    for (int i = 0; i < 2500; i++) begin
      logic [1:0] s;
      int x;
      s = 2'($urandom_range(0, 3));
      x = int'($urandom_range(0, 65535)) - 32768;
      step(s, x, got);
      exp = model_step(int'(s), x);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rand_%0d got %0d expected %0d", i, got, exp);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
